// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// ID/EX issue stage in front of the ALU. Resolves RV32I register/immediate
// operands (x0, EX forwarding, WB forwarding, register file), maps
// funct3/funct7b5 to the 4-bit ALU mode and registers operands, mode, rd and
// pc for the ALU one cycle later. Uses valid/ready handshakes on both sides,
// stalls on load-use hazards and supports flush.
// Optional feature: define ALU_ISSUE_UPPER_EN to add the i_op_upper port and
// LUI/AUIPC handling. Without the macro every instruction takes the normal path.
module alu_issue_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,

    // Upstream (decode) side
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [REG_AW-1:0] i_rs1_idx,
    input  logic [REG_AW-1:0] i_rs2_idx,
    input  logic [XLEN-1:0]   i_rs1_data,
    input  logic [XLEN-1:0]   i_rs2_data,
    input  logic [XLEN-1:0]   i_imm,
    input  logic              i_is_imm,
    input  logic [2:0]        i_funct3,
    input  logic              i_funct7b5,
    input  logic [REG_AW-1:0] i_rd,
    input  logic [XLEN-1:0]   i_pc,
`ifdef ALU_ISSUE_UPPER_EN
    input  logic [1:0]        i_op_upper,
`endif

    // EX-stage producer
    input  logic              i_ex_wen,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic [XLEN-1:0]   i_ex_data,
    input  logic              i_ex_is_load,

    // WB-stage producer
    input  logic              i_wb_wen,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic [XLEN-1:0]   i_wb_data,

    // Pipeline control
    input  logic              i_flush,

    // Downstream (ALU) side
    output logic              o_valid,
    input  logic              i_ready,
    output logic [XLEN-1:0]   o_alu_data_1,
    output logic [XLEN-1:0]   o_alu_data_2,
    output logic [3:0]        o_alu_mode,
    output logic [REG_AW-1:0] o_rd,
    output logic [XLEN-1:0]   o_pc
);

    localparam logic [REG_AW-1:0] REG_X0 = '0;

    // funct3 encodings that need the funct7b5 qualifier
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    // ALU mode used by LUI/AUIPC (plain addition)
    localparam logic [3:0] MODE_ADD = 4'b0000;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic              valid_q,  valid_d;
    logic [XLEN-1:0]   data_1_q, data_1_d;
    logic [XLEN-1:0]   data_2_q, data_2_d;
    logic [3:0]        mode_q,   mode_d;
    logic [REG_AW-1:0] rd_q,     rd_d;
    logic [XLEN-1:0]   pc_q,     pc_d;

    // ------------------------------------------------------------------
    // Combinational decode signals
    // ------------------------------------------------------------------
    logic              is_lui;
    logic              is_auipc;
    logic              is_upper;
    logic              rs2_used;
    logic              ex_fwd_ok;
    logic              ex_load_pending;
    logic              hazard;
    logic              accept;
    logic [XLEN-1:0]   rs1_fwd;
    logic [XLEN-1:0]   rs2_fwd;
    logic [XLEN-1:0]   op_1;
    logic [XLEN-1:0]   op_2;
    logic              mode_bit0;
    logic [3:0]        mode_in;

`ifdef ALU_ISSUE_UPPER_EN
    // 01 = LUI, 10 = AUIPC; 11 is not a legal upper op and is issued normally.
    assign is_lui   = (i_op_upper == 2'b01);
    assign is_auipc = (i_op_upper == 2'b10);
`else
    assign is_lui   = 1'b0;
    assign is_auipc = 1'b0;
`endif
    assign is_upper = is_lui | is_auipc;

    // I-type instructions never read rs2, so its index must not stall or forward.
    assign rs2_used = ~i_is_imm;

    // A non-load EX result is already computed and may be forwarded; a load
    // result only exists after memory, so it becomes a stall candidate.
    assign ex_fwd_ok       = i_ex_wen & ~i_ex_is_load;
    assign ex_load_pending = i_ex_wen &  i_ex_is_load & (i_ex_rd != REG_X0);

    // Load-use hazard: the EX load writes a register this instruction reads.
    // Upper-immediate ops read no registers and therefore never stall.
    always_comb begin
        hazard = 1'b0;
        if (i_valid && ex_load_pending && !is_upper) begin
            if (i_ex_rd == i_rs1_idx) begin
                hazard = 1'b1;
            end
            if (rs2_used && (i_ex_rd == i_rs2_idx)) begin
                hazard = 1'b1;
            end
        end
    end

    // Ready when the output slot is empty or being drained, and no stall.
    assign o_ready = (~valid_q | i_ready) & ~hazard;
    assign accept  = i_valid & o_ready;

    // Resolve rs1: x0 reads zero, EX beats WB, WB beats the register file.
    always_comb begin
        rs1_fwd = i_rs1_data;
        if (i_rs1_idx == REG_X0) begin
            rs1_fwd = '0;
        end else if (ex_fwd_ok && (i_ex_rd == i_rs1_idx)) begin
            rs1_fwd = i_ex_data;
        end else if (i_wb_wen && (i_wb_rd == i_rs1_idx)) begin
            rs1_fwd = i_wb_data;
        end
    end

    // Resolve rs2 with the same priority as rs1.
    always_comb begin
        rs2_fwd = i_rs2_data;
        if (i_rs2_idx == REG_X0) begin
            rs2_fwd = '0;
        end else if (ex_fwd_ok && (i_ex_rd == i_rs2_idx)) begin
            rs2_fwd = i_ex_data;
        end else if (i_wb_wen && (i_wb_rd == i_rs2_idx)) begin
            rs2_fwd = i_wb_data;
        end
    end

    // Choose the ALU operands; LUI adds the immediate to zero, AUIPC to pc.
    always_comb begin
        op_1 = rs1_fwd;
        op_2 = i_is_imm ? i_imm : rs2_fwd;
        if (is_lui) begin
            op_1 = '0;
            op_2 = i_imm;
        end else if (is_auipc) begin
            op_1 = i_pc;
            op_2 = i_imm;
        end
    end

    // Mode bit 0 selects SUB/SRA. Only shifts honour funct7b5 for I-type,
    // so ADDI with a negative immediate (bit 30 set) still adds.
    always_comb begin
        mode_bit0 = 1'b0;
        if (i_funct3 == F3_SRL_SRA) begin
            mode_bit0 = i_funct7b5;
        end else if ((i_funct3 == F3_ADD_SUB) && !i_is_imm) begin
            mode_bit0 = i_funct7b5;
        end
        mode_in = is_upper ? MODE_ADD : {i_funct3, mode_bit0};
    end

    // Next-state: flush kills everything, an accept loads the slot, a drain
    // without a new accept leaves a bubble, otherwise hold.
    always_comb begin
        valid_d  = valid_q;
        data_1_d = data_1_q;
        data_2_d = data_2_q;
        mode_d   = mode_q;
        rd_d     = rd_q;
        pc_d     = pc_q;
        if (i_flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            data_1_d = op_1;
            data_2_d = op_2;
            mode_d   = mode_in;
            rd_d     = i_rd;
            pc_d     = i_pc;
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output registers; reset clears them immediately, without a clock edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q  <= 1'b0;
            data_1_q <= '0;
            data_2_q <= '0;
            mode_q   <= '0;
            rd_q     <= '0;
            pc_q     <= '0;
        end else begin
            valid_q  <= valid_d;
            data_1_q <= data_1_d;
            data_2_q <= data_2_d;
            mode_q   <= mode_d;
            rd_q     <= rd_d;
            pc_q     <= pc_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_alu_data_1 = data_1_q;
    assign o_alu_data_2 = data_2_q;
    assign o_alu_mode   = mode_q;
    assign o_rd         = rd_q;
    assign o_pc         = pc_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: directed cases plus randomized traffic,
// checked through a scoreboard queue consumed by an output monitor.
// Define ALU_ISSUE_UPPER_EN for both DUT and bench to exercise LUI/AUIPC.
module tb_alu_issue_stage;

    typedef struct {
        logic        valid;
        logic [4:0]  rs1, rs2;
        logic [31:0] rs1_data, rs2_data;
        logic [31:0] imm;
        logic        is_imm;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [1:0]  up;
        logic        ex_wen;
        logic [4:0]  ex_rd;
        logic [31:0] ex_data;
        logic        ex_load;
        logic        wb_wen;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        flush;
        logic        ready;
    } stim_t;

    typedef struct {
        logic [31:0] d1, d2;
        logic [3:0]  mode;
        logic [4:0]  rd;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid, o_ready, i_is_imm, i_funct7b5;
    logic [4:0]  i_rs1_idx, i_rs2_idx, i_rd, i_ex_rd, i_wb_rd, o_rd;
    logic [31:0] i_rs1_data, i_rs2_data, i_imm, i_pc, i_ex_data, i_wb_data;
    logic [2:0]  i_funct3;
    logic [1:0]  i_op_upper;
    logic        i_ex_wen, i_ex_is_load, i_wb_wen, i_flush, o_valid, i_ready;
    logic [31:0] o_alu_data_1, o_alu_data_2, o_pc;
    logic [3:0]  o_alu_mode;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;
    exp_t sb[$];
    logic model_valid  = 1'b0;
    logic pending_drop = 1'b0;

    always #5 clk = ~clk;

    alu_issue_stage #(.XLEN(32), .REG_AW(5)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_rs1_idx    (i_rs1_idx),
        .i_rs2_idx    (i_rs2_idx),
        .i_rs1_data   (i_rs1_data),
        .i_rs2_data   (i_rs2_data),
        .i_imm        (i_imm),
        .i_is_imm     (i_is_imm),
        .i_funct3     (i_funct3),
        .i_funct7b5   (i_funct7b5),
        .i_rd         (i_rd),
        .i_pc         (i_pc),
`ifdef ALU_ISSUE_UPPER_EN
        .i_op_upper   (i_op_upper),
`endif
        .i_ex_wen     (i_ex_wen),
        .i_ex_rd      (i_ex_rd),
        .i_ex_data    (i_ex_data),
        .i_ex_is_load (i_ex_is_load),
        .i_wb_wen     (i_wb_wen),
        .i_wb_rd      (i_wb_rd),
        .i_wb_data    (i_wb_data),
        .i_flush      (i_flush),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_alu_data_1 (o_alu_data_1),
        .o_alu_data_2 (o_alu_data_2),
        .o_alu_mode   (o_alu_mode),
        .o_rd         (o_rd),
        .o_pc         (o_pc)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic is_upper_op(input stim_t s);
`ifdef ALU_ISSUE_UPPER_EN
        return (s.up == 2'b01) || (s.up == 2'b10);
`else
        return 1'b0;
`endif
    endfunction

    // Value architecturally visible for register idx at issue time.
    function automatic logic [31:0] reg_value(input logic [4:0] idx, input logic [31:0] rf, input stim_t s);
        if (idx == 5'd0) return 32'd0;
        if (s.ex_wen && !s.ex_load && s.ex_rd == idx) return s.ex_data;
        if (s.wb_wen && s.wb_rd == idx) return s.wb_data;
        return rf;
    endfunction

    // ALU mode named by instruction.
    function automatic logic [3:0] mode_of(input stim_t s);
        case (s.f3)
            3'd0:    return (!s.is_imm && s.f7) ? 4'b0001 : 4'b0000; // SUB / ADD(I)
            3'd1:    return 4'b0010;                                 // SLL
            3'd2:    return 4'b0100;                                 // SLT
            3'd3:    return 4'b0110;                                 // SLTU
            3'd4:    return 4'b1000;                                 // XOR
            3'd5:    return s.f7 ? 4'b1011 : 4'b1010;                // SRA / SRL
            3'd6:    return 4'b1100;                                 // OR
            default: return 4'b1110;                                 // AND
        endcase
    endfunction

    function automatic exp_t model(input stim_t s);
        exp_t e;
        e.d1   = reg_value(s.rs1, s.rs1_data, s);
        e.d2   = s.is_imm ? s.imm : reg_value(s.rs2, s.rs2_data, s);
        e.mode = mode_of(s);
        e.rd   = s.rd;
        e.pc   = s.pc;
`ifdef ALU_ISSUE_UPPER_EN
        if (s.up == 2'b01) begin e.d1 = 32'd0; e.d2 = s.imm; e.mode = 4'b0000; end
        if (s.up == 2'b10) begin e.d1 = s.pc;  e.d2 = s.imm; e.mode = 4'b0000; end
`endif
        return e;
    endfunction

    function automatic logic load_use(input stim_t s);
        if (!s.valid || !s.ex_wen || !s.ex_load || s.ex_rd == 5'd0 || is_upper_op(s)) return 1'b0;
        return (s.ex_rd == s.rs1) || (!s.is_imm && s.ex_rd == s.rs2);
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic stim_t idle();
        stim_t s;
        s.valid = 0; s.rs1 = 0; s.rs2 = 0; s.rs1_data = 0; s.rs2_data = 0;
        s.imm = 0; s.is_imm = 0; s.f3 = 0; s.f7 = 0; s.rd = 0; s.pc = 0; s.up = 0;
        s.ex_wen = 0; s.ex_rd = 0; s.ex_data = 0; s.ex_load = 0;
        s.wb_wen = 0; s.wb_rd = 0; s.wb_data = 0; s.flush = 0; s.ready = 1;
        return s;
    endfunction

    function automatic stim_t instr(input logic [4:0] rs1, input logic [31:0] d1,
                                    input logic [4:0] rs2, input logic [31:0] d2,
                                    input logic is_imm, input logic [31:0] imm,
                                    input logic [2:0] f3, input logic f7, input logic [4:0] rd);
        stim_t s = idle();
        s.valid = 1; s.rs1 = rs1; s.rs1_data = d1; s.rs2 = rs2; s.rs2_data = d2;
        s.is_imm = is_imm; s.imm = imm; s.f3 = f3; s.f7 = f7; s.rd = rd;
        s.pc = 32'h1000 + {27'd0, rd, 2'b00};
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.valid    = ($urandom_range(0, 9) < 8);
        s.rs1      = 5'($urandom_range(0, 7));
        s.rs2      = 5'($urandom_range(0, 7));
        s.rs1_data = $urandom;
        s.rs2_data = $urandom;
        s.imm      = $urandom;
        s.is_imm   = 1'($urandom_range(0, 1));
        s.f3       = 3'($urandom_range(0, 7));
        s.f7       = 1'($urandom_range(0, 1));
        s.rd       = 5'($urandom_range(0, 31));
        s.pc       = $urandom;
        s.up       = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : 2'b00;
        s.ex_wen   = 1'($urandom_range(0, 1));
        s.ex_rd    = 5'($urandom_range(0, 7));
        s.ex_data  = $urandom;
        s.ex_load  = ($urandom_range(0, 3) == 0);
        s.wb_wen   = 1'($urandom_range(0, 1));
        s.wb_rd    = 5'($urandom_range(0, 7));
        s.wb_data  = $urandom;
        s.flush    = ($urandom_range(0, 19) == 0);
        s.ready    = ($urandom_range(0, 3) != 0);
        return s;
    endfunction

    task automatic apply(input stim_t s);
        i_valid = s.valid; i_rs1_idx = s.rs1; i_rs2_idx = s.rs2;
        i_rs1_data = s.rs1_data; i_rs2_data = s.rs2_data; i_imm = s.imm;
        i_is_imm = s.is_imm; i_funct3 = s.f3; i_funct7b5 = s.f7; i_rd = s.rd;
        i_pc = s.pc; i_op_upper = s.up; i_ex_wen = s.ex_wen; i_ex_rd = s.ex_rd;
        i_ex_data = s.ex_data; i_ex_is_load = s.ex_load; i_wb_wen = s.wb_wen;
        i_wb_rd = s.wb_rd; i_wb_data = s.wb_data; i_flush = s.flush; i_ready = s.ready;
    endtask

    // One clock cycle of stimulus; predicts handshake and next valid state.
    task automatic step(input stim_t s);
        logic exp_ready;
        @(posedge clk);
        #1;
        if (pending_drop) begin
            if (sb.size() > 0) sb.delete(0);
            pending_drop = 1'b0;
        end
        chk("o_valid", 32'(o_valid), 32'(model_valid));
        apply(s);
        #1;
        exp_ready = (!model_valid || s.ready) && !load_use(s);
        chk("o_ready", 32'(o_ready), 32'(exp_ready));
        if (s.flush) begin
            if (model_valid && !s.ready) pending_drop = 1'b1;
            model_valid = 1'b0;
        end else if (s.valid && exp_ready) begin
            sb.push_back(model(s));
            model_valid = 1'b1;
        end else if (s.ready) begin
            model_valid = 1'b0;
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && o_valid) begin
                chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb[0];
                    chk("data_1", o_alu_data_1, e.d1);
                    chk("data_2", o_alu_data_2, e.d2);
                    chk("mode", 32'(o_alu_mode), 32'(e.mode));
                    chk("rd", 32'(o_rd), 32'(e.rd));
                    chk("pc", o_pc, e.pc);
                    if (i_ready) begin
                        sb.delete(0);
                        n_txn++;
                        $display("txn %0d: d1=%h d2=%h mode=%b rd=%0d pc=%h",
                                 n_txn, o_alu_data_1, o_alu_data_2, o_alu_mode, o_rd, o_pc);
                    end
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        stim_t s;
        apply(idle());
        #3;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_data_1", o_alu_data_1, 32'd0);
        chk("rst_data_2", o_alu_data_2, 32'd0);
        chk("rst_mode", 32'(o_alu_mode), 32'd0);
        chk("rst_rd", 32'(o_rd), 32'd0);
        chk("rst_pc", o_pc, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // SUB x5(10) - x6(3), then ADDI imm=-1 with bit30 set, then SRAI
        step(instr(5'd5, 32'd10, 5'd6, 32'd3, 1'b0, 32'd0, 3'b000, 1'b1, 5'd7));
        step(instr(5'd1, 32'd4, 5'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 3'b000, 1'b1, 5'd8));
        chk("sub_data_1", o_alu_data_1, 32'd10);
        chk("sub_data_2", o_alu_data_2, 32'd3);
        chk("sub_mode", 32'(o_alu_mode), 32'b0001);
        step(instr(5'd2, 32'h8000_0000, 5'd0, 32'd0, 1'b1, 32'd3, 3'b101, 1'b1, 5'd9));
        chk("addi_mode", 32'(o_alu_mode), 32'b0000);
        chk("addi_data_2", o_alu_data_2, 32'hFFFF_FFFF);
        step(idle());
        chk("srai_mode", 32'(o_alu_mode), 32'b1011);

        // Forwarding priority: EX over WB, WB over stale RF, x0 always zero
        s = instr(5'd5, 32'd0, 5'd0, 32'd0, 1'b1, 32'd1, 3'b000, 1'b0, 5'd3);
        s.ex_wen = 1; s.ex_rd = 5'd5; s.ex_data = 32'd7;
        s.wb_wen = 1; s.wb_rd = 5'd5; s.wb_data = 32'd9;
        step(s);
        s.ex_wen = 0;
        step(s);
        chk("fwd_ex", o_alu_data_1, 32'd7);
        s.rs1 = 5'd0; s.rs1_data = 32'h55; s.ex_wen = 1; s.ex_rd = 5'd0; s.wb_rd = 5'd0;
        step(s);
        chk("fwd_wb", o_alu_data_1, 32'd9);
        step(idle());
        chk("fwd_x0", o_alu_data_1, 32'd0);

        // Load-use stall on rs2, then release with WB forwarding
        s = instr(5'd1, 32'd1, 5'd6, 32'd0, 1'b0, 32'd0, 3'b111, 1'b0, 5'd10);
        s.ex_wen = 1; s.ex_load = 1; s.ex_rd = 5'd6;
        step(s);
        chk("hazard_ready", 32'(o_ready), 32'd0);
        s.ex_wen = 0; s.ex_load = 0; s.wb_wen = 1; s.wb_rd = 5'd6; s.wb_data = 32'h1234;
        step(s);
        step(idle());
        chk("hazard_wb_data_2", o_alu_data_2, 32'h1234);

        // Downstream backpressure for 3 cycles while a new instruction waits
        step(instr(5'd2, 32'hA, 5'd3, 32'hB, 1'b0, 32'd0, 3'b110, 1'b0, 5'd11));
        s = instr(5'd4, 32'hC, 5'd0, 32'd0, 1'b1, 32'h20, 3'b100, 1'b0, 5'd12);
        s.ready = 0;
        for (int k = 0; k < 3; k++) begin
            step(s);
            chk("hold_ready", 32'(o_ready), 32'd0);
        end
        s.ready = 1;
        step(s);
        step(idle());
        chk("after_hold_rd", 32'(o_rd), 32'd12);

        // Flush with a same-cycle accept, then flush of a held instruction
        step(instr(5'd1, 32'd1, 5'd2, 32'd2, 1'b0, 32'd0, 3'b000, 1'b0, 5'd13));
        s = instr(5'd3, 32'd3, 5'd4, 32'd4, 1'b0, 32'd0, 3'b001, 1'b0, 5'd14);
        s.flush = 1;
        step(s);
        step(idle());
        step(instr(5'd1, 32'd1, 5'd2, 32'd2, 1'b0, 32'd0, 3'b010, 1'b0, 5'd15));
        s.ready = 0;
        step(s);
        step(idle());

        // Asynchronous reset while an instruction is held
        step(instr(5'd1, 32'hDEAD, 5'd2, 32'hBEEF, 1'b0, 32'd0, 3'b011, 1'b0, 5'd16));
        s = idle();
        s.ready = 0;
        step(s);
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(o_valid), 32'd0);
        chk("arst_data_1", o_alu_data_1, 32'd0);
        chk("arst_data_2", o_alu_data_2, 32'd0);
        chk("arst_mode", 32'(o_alu_mode), 32'd0);
        chk("arst_rd", 32'(o_rd), 32'd0);
        chk("arst_pc", o_pc, 32'd0);
        sb.delete();
        model_valid  = 1'b0;
        pending_drop = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            step(rand_stim());
        end

        step(idle());
        step(idle());
        step(idle());
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX boundary stage directly upstream of the ALU.
- Takes decoded RV32I register/immediate ALU instructions and resolves operands by forwarding from EX and WB.
- Translates funct3/funct7 to the 4-bit ALU mode and registers operands, mode and rd for the ALU in the next cycle.
- Uses a valid/ready handshake on both sides; stalls on load-use hazards and supports pipeline flush.

Parameters:
- XLEN, 32, datapath width. Must equal the ALU width.
- REG_AW, 5, register index width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  upstream instruction valid.
- o_ready  out  1  stage can accept this cycle.
- i_rs1_idx, i_rs2_idx  in  REG_AW  source indices.
- i_rs1_data, i_rs2_data  in  XLEN  register-file read data.
- i_imm  in  XLEN  sign-extended immediate.
- i_is_imm  in  1  1 = I-type: operand 2 is i_imm and rs2 is unused.
- i_funct3  in  3  RV funct3.
- i_funct7b5  in  1  instruction bit 30.
- i_rd  in  REG_AW  destination.
- i_pc  in  XLEN  instruction PC.
- i_op_upper  in  2  00 normal, 01 LUI, 10 AUIPC. Only with the optional feature.
- i_ex_wen, i_ex_rd, i_ex_data, i_ex_is_load  in  1/REG_AW/XLEN/1  EX-stage producer.
- i_wb_wen, i_wb_rd, i_wb_data  in  1/REG_AW/XLEN  WB-stage producer.
- i_flush  in  1  kill the held and incoming instruction.
- o_valid  out  1  ALU inputs valid.
- i_ready  in  1  downstream accepts.
- o_alu_data_1, o_alu_data_2  out  XLEN  ALU operands.
- o_alu_mode  out  4  ALU mode.
- o_rd  out  REG_AW  destination.
- o_pc  out  XLEN  passed-through PC.

Behaviour:
- Reset (async, i_rst=1): o_valid=0, o_alu_data_1=0, o_alu_data_2=0, o_alu_mode=0, o_rd=0, o_pc=0.
- o_ready: combinational, equal to (!o_valid | i_ready) & !hazard.
- hazard: i_valid & i_ex_wen & i_ex_is_load & i_ex_rd!=0 & (i_ex_rd==i_rs1_idx | (!i_is_imm & i_ex_rd==i_rs2_idx)).
- Accept: i_valid & o_ready. Output registers load on the next rising edge; latency is 1 cycle.
- Hold: o_valid & !i_ready. All outputs stay stable; no field changes while valid and unaccepted.
- Bubble: if downstream drains (o_valid & i_ready) and nothing is accepted (hazard or !i_valid), then o_valid goes to 0.
- Forwarding, per source index s:
  - s==0 gives 0.
  - Else if i_ex_wen & !i_ex_is_load & i_ex_rd==s, use i_ex_data.
  - Else if i_wb_wen & i_wb_rd==s, use i_wb_data.
  - Else use register-file data.
  - EX has priority over WB.
- Operand 2: i_is_imm ? i_imm : forwarded rs2.
- Mode mapping: o_alu_mode[3:1] = i_funct3.
- Mode bit 0:
  - For R-type: funct3=000 or 101 gives i_funct7b5; all other funct3 give 0.
  - For I-type: funct3=101 gives i_funct7b5 (SRAI); all other funct3 give 0, so ADDI never subtracts.
- Resulting codes: ADD 0000, SUB 0001, SLL 0010, SLT 0100, SLTU 0110, XOR 1000, SRL 1010, SRA 1011, OR 1100, AND 1110.
- Flush: i_flush=1 at an edge sets o_valid=0 and discards any same-cycle accept. Data registers may keep stale values. Flush overrides hold.
- Reset mid-hold: the held instruction is lost and o_valid=0 immediately.

Optional Feature:
- Macro ALU_ISSUE_UPPER_EN.
- Defined:
  - i_op_upper=01 (LUI) produces data_1=0, data_2=i_imm, mode ADD.
  - i_op_upper=10 (AUIPC) produces data_1=i_pc, data_2=i_imm, mode ADD.
  - Neither LUI nor AUIPC forwards or triggers the hazard check.
- Not defined: the i_op_upper port is absent and all instructions take the normal path.

Test Plan:
- R-type SUB, rs1=x5 (data 10), rs2=x6 (data 3), funct7b5=1 -> one cycle later o_valid=1, data_1=10, data_2=3, mode=0001.
- ADDI with funct7b5=1, imm=-1 -> mode=0000 and data_2=32'hFFFFFFFF. SRAI with funct7b5=1 -> mode=1011.
- x5 read stale 0, with EX rd=5 data 7 and WB rd=5 data 9 -> data_1=7. With EX wen=0 -> data_1=9. With rs1=x0 and any producer -> data_1=0.
- EX load rd=6, instruction uses rs2=x6 -> o_ready=0 for that cycle and o_valid drops to 0. When load clears -> accepted with forwarded WB value.
- i_ready=0 for 3 cycles while upstream presents a new instruction -> outputs unchanged and o_ready=0. When i_ready=1 -> the next instruction loads on the following edge.
- i_flush while o_valid=1 and a new instruction is accepted -> o_valid=0 next cycle. Async i_rst mid-hold -> all outputs 0 without a clock edge.
